// File: rtl/wb_pkg.sv
// Shared write-back definitions: register address width, register count and the zero register.
// Used by the write arbiter, the register file and the rename logic.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Result-collection and regfile-write bundle between the functional units and the
// write arbiter.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 3
);

    logic                       flush_i;
    logic [NSRC-1:0]            src_valid_i;
    logic [NSRC-1:0]            src_ready_o;
    logic [REG_ADDR_W*NSRC-1:0] src_rd_addr_i;
    logic [WIDTH*NSRC-1:0]      src_data_i;
    logic                       w_en_o;
    reg_addr_t                  rd_addr_o;
    logic [WIDTH-1:0]           w_data_o;
    logic                       pending_o;

    // Producer side: functional units plus the regfile write sink.
    modport master (
        output flush_i, src_valid_i, src_rd_addr_i, src_data_i,
        input  src_ready_o, w_en_o, rd_addr_o, w_data_o, pending_o
    );

    modport slave (
        input  flush_i, src_valid_i, src_rd_addr_i, src_data_i,
        output src_ready_o, w_en_o, rd_addr_o, w_data_o, pending_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or above ptr_i, wrapping
// from N-1 back to 0. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter  int unsigned N    = 3,
    localparam int unsigned PtrW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [PtrW-1:0] grant_idx_o,
    output logic            any_grant_o
);

    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PtrW'((32'(ptr_i) + off) % N);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                found        = 1'b1;
            end
        end
        any_grant_o = found;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-side front end of the single-write-port regfile: one holding register per
// functional unit, drained round-robin onto a registered write port.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 3
) (
    input logic        clk_i,
    input logic        reset_i,
    wb_arbiter_if.slave bus
);

    localparam int unsigned PtrW = $clog2(NSRC);

    logic [NSRC-1:0]  buf_vld_q, buf_vld_d;
    reg_addr_t        buf_rd_q   [NSRC];
    reg_addr_t        buf_rd_d   [NSRC];
    logic [WIDTH-1:0] buf_data_q [NSRC];
    logic [WIDTH-1:0] buf_data_d [NSRC];

    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]  grant_idx;
    logic [NSRC-1:0]  grant;
    logic             any_grant;

    logic [NSRC-1:0]  src_ready;
    logic [NSRC-1:0]  load;

    logic             w_en_q, w_en_d;
    reg_addr_t        rd_addr_q, rd_addr_d;
    logic [WIDTH-1:0] w_data_q, w_data_d;

    rr_arbiter #(
        .N (NSRC)
    ) u_rr_arbiter (
        .req_i       (buf_vld_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    // A buffer being drained this cycle may be refilled on the same edge.
    assign src_ready = {NSRC{reset_i & ~bus.flush_i}} & (~buf_vld_q | grant);

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        // Results for x0 complete the handshake but are never buffered.
        assign load[i] = bus.src_valid_i[i] & src_ready[i] &
                         ~is_zero_reg(bus.src_rd_addr_i[REG_ADDR_W*i +: REG_ADDR_W]);

        assign buf_vld_d[i]  = bus.flush_i ? 1'b0 :
                               load[i]     ? 1'b1 :
                               grant[i]    ? 1'b0 : buf_vld_q[i];
        assign buf_rd_d[i]   = load[i] ? bus.src_rd_addr_i[REG_ADDR_W*i +: REG_ADDR_W]
                                       : buf_rd_q[i];
        assign buf_data_d[i] = load[i] ? bus.src_data_i[WIDTH*i +: WIDTH] : buf_data_q[i];

        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                buf_rd_q[i]   <= ZERO_REG;
                buf_data_q[i] <= '0;
            end else begin
                buf_rd_q[i]   <= buf_rd_d[i];
                buf_data_q[i] <= buf_data_d[i];
            end
        end
    end

    always_comb begin
        w_en_d    = 1'b0;
        rd_addr_d = rd_addr_q;
        w_data_d  = w_data_q;
        rr_ptr_d  = rr_ptr_q;
        if (!bus.flush_i && any_grant) begin
            w_en_d    = 1'b1;
            rd_addr_d = buf_rd_q[grant_idx];
            w_data_d  = buf_data_q[grant_idx];
            rr_ptr_d  = (grant_idx == PtrW'(NSRC - 1)) ? '0 : grant_idx + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            buf_vld_q <= '0;
            rr_ptr_q  <= '0;
            w_en_q    <= 1'b0;
            rd_addr_q <= ZERO_REG;
            w_data_q  <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            rr_ptr_q  <= rr_ptr_d;
            w_en_q    <= w_en_d;
            rd_addr_q <= rd_addr_d;
            w_data_q  <= w_data_d;
        end
    end

    assign bus.src_ready_o = src_ready;
    assign bus.w_en_o      = w_en_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.w_data_o    = w_data_q;
    assign bus.pending_o   = (|buf_vld_q) | w_en_q;

endmodule
